// File: rtl/lacpu_bus_pkg.sv
// lacpu_bus_pkg: shared port ids and arbiter priority encoding for the LACPU SRAM bus.
package lacpu_bus_pkg;

    typedef enum logic {
        PORT_INST = 1'b0,
        PORT_DATA = 1'b1
    } port_id_e;

    typedef enum logic {
        PRI_DATA = 1'b0,
        PRI_INST = 1'b1
    } pri_e;

endpackage

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port SRAM between the instruction and data ports,
// with data-first priority bounded by a starvation limit for the instruction port.
module sram_arbiter
    import lacpu_bus_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inst_req,
    input  logic [31:0]   inst_addr,
    output logic          inst_addr_ok,
    output logic          inst_data_ok,
    output logic [31:0]   inst_rdata,
    input  logic          data_req,
    input  logic [3:0]    data_wen,
    input  logic [31:0]   data_addr,
    input  logic [31:0]   data_wdata,
    output logic          data_addr_ok,
    output logic          data_data_ok,
    output logic [31:0]   data_rdata,
    output logic          ram_en,
    output logic [3:0]    ram_wen,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata,
    output logic [31:0]   inst_stall_cnt
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    pri_e          state;
    port_id_e      own_id;
    logic          own_vld;
    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_nxt;
    logic [31:0]   stall_cnt;
    logic          gnt_inst;
    logic          gnt_data;
    logic          unused_addr;

    always_comb begin
        gnt_data   = !reset && data_req && (!inst_req || state == PRI_DATA);
        gnt_inst   = !reset && inst_req && !gnt_data;
        starve_nxt = (gnt_inst || !inst_req) ? '0 :
                     (gnt_data && starve_cnt != LIMIT) ? starve_cnt + 1'b1 : starve_cnt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= PRI_DATA;
            starve_cnt <= '0;
            own_vld    <= 1'b0;
            own_id     <= PORT_INST;
            stall_cnt  <= '0;
        end else begin
            state      <= gnt_inst ? PRI_DATA : (starve_nxt == LIMIT) ? PRI_INST : state;
            starve_cnt <= starve_nxt;
            own_vld    <= gnt_inst || gnt_data;
            own_id     <= gnt_data ? PORT_DATA : PORT_INST;
            stall_cnt  <= stall_cnt + 32'(inst_req && !gnt_inst);
        end
    end

    // Responses are gated by reset so a grant just before reset never completes.
    assign inst_addr_ok   = gnt_inst;
    assign data_addr_ok   = gnt_data;
    assign inst_data_ok   = !reset && own_vld && own_id == PORT_INST;
    assign data_data_ok   = !reset && own_vld && own_id == PORT_DATA;
    assign inst_rdata     = ram_rdata;
    assign data_rdata     = ram_rdata;
    assign ram_en         = gnt_inst || gnt_data;
    assign ram_wen        = gnt_data ? data_wen : 4'b0000;
    assign ram_addr       = gnt_data ? data_addr[AW+1:2] : gnt_inst ? inst_addr[AW+1:2] : '0;
    assign ram_wdata      = gnt_data ? data_wdata : 32'd0;
    assign inst_stall_cnt = reset ? 32'd0 : stall_cnt;
    assign unused_addr    = ^{inst_addr[31:AW+2], inst_addr[1:0], data_addr[31:AW+2], data_addr[1:0]};

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: table-driven vectors with a response scoreboard, plus a reset-abort sequence.
module tb_sram_arbiter;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          inst_req;
    logic [31:0]   inst_addr;
    logic          inst_addr_ok;
    logic          inst_data_ok;
    logic [31:0]   inst_rdata;
    logic          data_req;
    logic [3:0]    data_wen;
    logic [31:0]   data_addr;
    logic [31:0]   data_wdata;
    logic          data_addr_ok;
    logic          data_data_ok;
    logic [31:0]   data_rdata;
    logic          ram_en;
    logic [3:0]    ram_wen;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata = 32'd0;
    logic [31:0]   inst_stall_cnt;

    sram_arbiter #(.STARVE_LIMIT(4), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .inst_stall_cnt(inst_stall_cnt)
    );

    always #5 clk = ~clk;

    // Behavioral single-port RAM with one-cycle read latency.
    logic [31:0] mem [0:63];
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= mem[ram_addr[5:0]];
            for (int b = 0; b < 4; b++)
                if (ram_wen[b]) mem[ram_addr[5:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic [3:0]  dw;
        logic [31:0] da;
        logic [31:0] dd;
        logic        gi;
        logic        gd;
        logic        rchk;
        logic [31:0] rval;
    } vec_t;

    typedef struct {
        logic        iok;
        logic        dok;
        logic        rchk;
        logic [31:0] rval;
    } rsp_t;

    vec_t        vecs[$];
    rsp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_stall = 32'd0;

    function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                                input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd,
                                input logic gi, input logic gd, input logic rchk, input logic [31:0] rval);
        vec_t v;
        v = '{ir, ia, dr, dw, da, dd, gi, gd, rchk, rval};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input vec_t v);
        rsp_t r;
        inst_req   = v.ir;
        inst_addr  = v.ia;
        data_req   = v.dr;
        data_wen   = v.dw;
        data_addr  = v.da;
        data_wdata = v.dd;
        @(negedge clk);
        chk("inst_addr_ok", 32'(inst_addr_ok), 32'(v.gi));
        chk("data_addr_ok", 32'(data_addr_ok), 32'(v.gd));
        chk("ram_en", 32'(ram_en), 32'(v.gi | v.gd));
        chk("ram_addr", 32'(ram_addr), v.gd ? 32'(v.da[17:2]) : v.gi ? 32'(v.ia[17:2]) : 32'd0);
        chk("ram_wen", 32'(ram_wen), v.gd ? 32'(v.dw) : 32'd0);
        chk("ram_wdata", ram_wdata, v.gd ? v.dd : 32'd0);
        chk("inst_stall_cnt", inst_stall_cnt, exp_stall);
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty actual=0 expected=1");
        end else begin
            r = sbq.pop_front();
            chk("inst_data_ok", 32'(inst_data_ok), 32'(r.iok));
            chk("data_data_ok", 32'(data_data_ok), 32'(r.dok));
            if (r.rchk) chk("data_rdata", data_rdata, r.rval);
            if (r.iok) chk("inst_rdata", inst_rdata, ram_rdata);
        end
        exp_stall += 32'(v.ir && !v.gi);
        sbq.push_back('{v.gi, v.gd, v.rchk, v.rval});
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; inst_req = 1'b1; inst_addr = 32'h1C00_0010;
        data_req = 1'b1; data_wen = 4'hF; data_addr = 32'h8; data_wdata = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        chk("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        chk("rst_data_addr_ok", 32'(data_addr_ok), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_ram_wen", 32'(ram_wen), 32'd0);
        chk("rst_inst_data_ok", 32'(inst_data_ok), 32'd0);
        chk("rst_data_data_ok", 32'(data_data_ok), 32'd0);
        chk("rst_stall", inst_stall_cnt, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sbq.push_back('{1'b0, 1'b0, 1'b0, 32'd0});

        for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 32'h1C00_0010, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(1, 32'h100, 1, 0, 32'h200, 0, i % 5 == 4, i % 5 != 4, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 4'b0011, 32'h8, 32'hDEAD_BEEF, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 4'hF, 32'h20, 32'hDEAD_BEEF, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 4'h0, 32'h20, 0, 0, 1, 1, 32'hDEAD_BEEF));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 32'h40, i % 2 == 0, 0, 32'h44, 0, i % 2 == 1, i % 2 == 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (vecs[i]) step(vecs[i]);

        // Grant inst, then reset the very next cycle: its response must never appear.
        step(mk(1, 32'h1C00_0010, 0, 0, 0, 0, 1, 0, 0, 0));
        reset = 1'b1;
        @(negedge clk);
        chk("abort_inst_data_ok_t1", 32'(inst_data_ok), 32'd0);
        chk("abort_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        chk("abort_ram_en", 32'(ram_en), 32'd0);
        chk("abort_ram_wen", 32'(ram_wen), 32'd0);
        chk("abort_data_data_ok", 32'(data_data_ok), 32'd0);
        chk("abort_stall", inst_stall_cnt, 32'd0);
        sbq.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        inst_req = 1'b0;
        @(negedge clk);
        chk("abort_inst_data_ok_t2", 32'(inst_data_ok), 32'd0);
        chk("abort_ram_en_t2", 32'(ram_en), 32'd0);
        chk("abort_stall_t2", inst_stall_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, max consecutive data grants while inst is waiting.
REQ-002 Parameter: AW, default 16, RAM word-address width; RAM word address = requester addr[AW+1:2].
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 inst_req  in  1  instruction-port request valid.
REQ-006 inst_addr  in  32  instruction byte address.
REQ-007 inst_addr_ok  out  1  instruction request accepted this cycle.
REQ-008 inst_data_ok  out  1  instruction read data valid this cycle.
REQ-009 inst_rdata  out  32  instruction read data.
REQ-010 data_req  in  1  data-port request valid.
REQ-011 data_wen  in  4  byte write enables; 0 = read.
REQ-012 data_addr  in  32  data byte address.
REQ-013 data_wdata  in  32  data write data.
REQ-014 data_addr_ok  out  1  data request accepted this cycle.
REQ-015 data_data_ok  out  1  data response (read data or write done) this cycle.
REQ-016 data_rdata  out  32  data read data.
REQ-017 ram_en, ram_wen[4], ram_addr[AW], ram_wdata[32]  out  single-port RAM request.
REQ-018 ram_rdata  in  32  RAM read data, valid one cycle after ram_en.
REQ-019 inst_stall_cnt  out  32  count of cycles with inst_req=1 and inst_addr_ok=0.

Function
REQ-020 The block shall grant at most one requester per cycle; the grant is combinational from req inputs and registered priority state.
REQ-021 Grant to a port shall assert that port's addr_ok and drive ram_en=1 with its address/wen/wdata in the same cycle; inst grants drive ram_wen=0, ram_wdata=0.
REQ-022 No grant: ram_en=0, ram_wen=0, both addr_ok=0.
REQ-023 Priority FSM states: PRI_DATA (data wins on conflict) and PRI_INST (inst wins on conflict); reset state PRI_DATA.
REQ-024 starve_cnt shall increment on each cycle with data granted while inst_req=1, clear on any inst grant or when inst_req=0, and saturate at STARVE_LIMIT.
REQ-025 PRI_DATA -> PRI_INST when starve_cnt reaches STARVE_LIMIT; PRI_INST -> PRI_DATA after one inst grant.
REQ-026 Sole requester is always granted regardless of FSM state.
REQ-027 Response latency exactly 1 cycle: a grant in cycle T shall raise the owner's data_ok in T+1 only; a one-entry owner register (valid, id) tracks this.
REQ-028 Grants are fully pipelined: a new grant in T+1 is allowed while the T response returns.
REQ-029 inst_rdata and data_rdata shall both equal ram_rdata; only the owner's data_ok qualifies it.
REQ-030 Writes shall also produce data_data_ok in T+1; data_rdata content is don't-care then.
REQ-031 inst_stall_cnt shall wrap modulo 2^32.
REQ-032 Requesters hold req/addr/wen/wdata stable until addr_ok; arbiter does not latch unaccepted requests.

Reset
REQ-033 While reset=1: all addr_ok, data_ok, ram_en, ram_wen =0; FSM=PRI_DATA; starve_cnt=0; owner valid=0; inst_stall_cnt=0.
REQ-034 Reset asserted in the cycle after a grant shall suppress that grant's data_ok; no response is delivered after reset.

Structure
REQ-035 Port IDs (INST=0, DATA=1) and FSM state encoding shall live in shared package lacpu_bus_pkg.
REQ-036 Single module; no sub-module. Starvation counter and owner register are inline.

Verification
REQ-037 Inst only, inst_addr=0x1C00_0010 for 3 cycles -> addr_ok each cycle, ram_addr=0x0004, inst_data_ok in cycles 2-4, inst_stall_cnt=0.
REQ-038 Both req held for 10 cycles, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I; inst_stall_cnt=8.
REQ-039 Data write wen=4'b0011 addr=0x0000_0008 wdata=0xDEADBEEF -> ram_en=1, ram_wen=0011, ram_addr=0x0002; data_data_ok next cycle; inst_data_ok=0.
REQ-040 Read-after-write: data write to 0x20, then data read to 0x20 -> read's data_ok cycle shows 0xDEADBEEF.
REQ-041 Grant inst in T, reset=1 in T+1 -> inst_data_ok=0 in T+1 and T+2; all outputs at reset values.
REQ-042 inst_req held, data_req toggling 1,0,1,0 -> starve_cnt never reaches limit on toggling pattern; inst granted on every data-idle cycle.
